ram8: RTL and testbench



---
 rtl/ram8_if.sv | 11 +
 rtl/ram8.sv | 34 +++
 tb/tb_ram8.sv | 132 +++++++++++++
 3 files changed

// File: rtl/ram8_if.sv
// Bus bundle for the 8x16 register-file memory: write data, address, write
// enable and the combinational read word.
interface ram8_if;
  logic [15:0] in;
  logic [2:0]  addr;
  logic        load;
  logic [15:0] out;

  modport master (output in, output addr, output load, input out);
  modport slave  (input in, input addr, input load, output out);
endinterface

// File: rtl/ram8.sv
// Eight-word by 16-bit register file: one write per rising edge when load is
// set, combinational read of the addressed word, asynchronous clear.
module ram8 (
  input  logic  clk,
  input  logic  reset,
  ram8_if.slave bus
);

  logic [7:0]       wr_en;
  logic [7:0][15:0] words;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_word
      logic [15:0] word_reg;

      // Demux: load reaches only the register selected by addr.
      assign wr_en[gi] = bus.load && (bus.addr == 3'(gi));

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          word_reg <= 16'h0000;
        end else if (wr_en[gi]) begin
          word_reg <= bus.in;
        end
      end

      assign words[gi] = word_reg;
    end
  endgenerate

  // No bypass: a word being written shows its old value until the edge.
  assign bus.out = words[bus.addr];

endmodule

// File: tb/tb_ram8.sv
// Self-checking bench for ram8: a reference model feeds expected read values
// into a queue, which are popped and compared against out.
module tb_ram8;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  logic [15:0] model [8];
  logic [15:0] exp_q [$];

  ram8_if bus ();

  ram8 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: out=%h", tag, obs);
    end
  endtask

  task automatic read_check(input logic [2:0] a, input string tag);
    bus.addr = a;
    exp_q.push_back(model[a]);
    #1;
    check($sformatf("%s addr%0d", tag, a), bus.out, exp_q.pop_front());
  endtask

  task automatic sweep(input string tag);
    for (int k = 0; k < 8; k++) read_check(3'(k), tag);
  endtask

  task automatic write_word(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    bus.addr = a;
    bus.in   = d;
    bus.load = 1'b1;
    @(posedge clk);
    if (!reset) model[a] = d;
    #1;
    bus.load = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    for (int k = 0; k < 8; k++) model[k] = 16'h0000;
    bus.in   = 16'h0000;
    bus.addr = 3'd0;
    bus.load = 1'b0;
    reset    = 1'b1;

    #2;
    sweep("reset");

    // Edge with load=1 while reset is held must not write.
    write_word(3'd1, 16'hFFFF);
    read_check(3'd1, "reset_blocks_write");

    @(negedge clk);
    reset = 1'b0;

    for (int k = 0; k < 8; k++) write_word(3'(k), 16'hABCD + 16'(k));
    sweep("write_all");

    // No-load hold with a different value on in.
    write_word(3'd3, 16'h1234);
    bus.addr = 3'd3;
    bus.in   = 16'hFFFF;
    for (int e = 0; e < 4; e++) begin
      @(posedge clk);
      #1;
      read_check(3'd3, $sformatf("hold_edge%0d", e));
    end

    for (int k = 0; k < 8; k++) write_word(3'(k), 16'h0000);
    write_word(3'd5, 16'hBEEF);
    sweep("isolation");

    // Same-cycle read/write of R2.
    write_word(3'd2, 16'h0001);
    @(negedge clk);
    bus.addr = 3'd2;
    bus.in   = 16'h0002;
    bus.load = 1'b1;
    read_check(3'd2, "rw_before_edge");
    @(posedge clk);
    model[2] = 16'h0002;
    #1;
    bus.load = 1'b0;
    read_check(3'd2, "rw_after_edge");

    // Asynchronous reset pulse between edges with load asserted.
    for (int k = 0; k < 8; k++) write_word(3'(k), 16'h1111 * 16'(k + 1));
    sweep("prefill");
    @(negedge clk);
    bus.addr = 3'd4;
    bus.in   = 16'h5555;
    bus.load = 1'b1;
    #1;
    reset = 1'b1;
    for (int k = 0; k < 8; k++) model[k] = 16'h0000;
    read_check(3'd4, "async_reset_immediate");
    @(posedge clk);
    #1;
    read_check(3'd4, "write_during_reset");
    @(negedge clk);
    bus.load = 1'b0;
    reset    = 1'b0;
    sweep("after_reset");

    // Normal write right after reset release.
    write_word(3'd6, 16'hC0DE);
    sweep("post_reset_write");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
